// File: rtl/rv32i_mem_responder_if.sv
// Instruction-fetch and data-memory bus between the rv32i core (master) and its memory (slave).
interface rv32i_mem_responder_if #(
  parameter int unsigned size = 32
) ();
  logic [size-1:0] ins_address;
  logic [size-1:0] instruction_i;
  logic            instruction_valid;
  logic            data_mem_rw;
  logic [size-1:0] data_mem_addr_o;
  logic [size-1:0] data_mem_data_wr_data;
  logic [size-1:0] data_mem_data_rd_data;
  logic [2:0]      data_mem_control;

  modport master (
    output ins_address,
    input  instruction_i,
    input  instruction_valid,
    output data_mem_rw,
    output data_mem_addr_o,
    output data_mem_data_wr_data,
    input  data_mem_data_rd_data,
    output data_mem_control
  );

  modport slave (
    input  ins_address,
    output instruction_i,
    output instruction_valid,
    input  data_mem_rw,
    input  data_mem_addr_o,
    input  data_mem_data_wr_data,
    output data_mem_data_rd_data,
    input  data_mem_control
  );
endinterface

// File: rtl/rv32i_mem_responder.sv
// Unified word-addressed RAM serving rv32i fetch and byte/half/word load/store ports.
// Define RV_IMEM_WAIT_STATES_EN to insert IMEM_WAIT fetch wait cycles through a small FSM.
module rv32i_mem_responder #(
  parameter int unsigned size        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IMEM_WAIT   = 2,
  parameter string       INIT_FILE   = ""
) (
  input logic                  clk,
  input logic                  reset,
  rv32i_mem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [size-1:0] Nop = size'(32'h0000_0013);

  logic [size-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0] data_idx;
  logic [1:0]    data_off;
  assign data_idx = bus.data_mem_addr_o[AW+1:2];
  assign data_off = bus.data_mem_addr_o[1:0];

  // Upper address bits are ignored so the RAM aliases modulo 4*DEPTH_WORDS.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ins_address[size-1:AW+2], bus.ins_address[1:0],
                              bus.data_mem_addr_o[size-1:AW+2]};

  // Store byte enables: only control[1:0] selects the width, so 100/101 store as B/H.
  logic [3:0]      st_be;
  logic [size-1:0] st_data;
  always_comb begin
    st_be   = 4'b0000;
    st_data = bus.data_mem_data_wr_data;
    case (bus.data_mem_control)
      3'b000, 3'b100: begin
        st_be   = 4'b0001 << data_off;
        st_data = {4{bus.data_mem_data_wr_data[7:0]}};
      end
      3'b001, 3'b101: begin
        st_be   = data_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.data_mem_data_wr_data[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.data_mem_rw) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[data_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Loads capture the raw word; lane extraction happens on the registered copy.
  logic [size-1:0] ld_word_q;
  logic [1:0]      ld_off_q;
  logic [2:0]      ld_ctrl_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_word_q <= '0;
      ld_off_q  <= '0;
      ld_ctrl_q <= '0;
    end else if (!bus.data_mem_rw) begin
      ld_word_q <= mem[data_idx];
      ld_off_q  <= data_off;
      ld_ctrl_q <= bus.data_mem_control;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    ld_byte = ld_word_q[8*ld_off_q +: 8];
    ld_half = ld_word_q[16*ld_off_q[1] +: 16];
    case (ld_ctrl_q)
      3'b000:  bus.data_mem_data_rd_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  bus.data_mem_data_rd_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  bus.data_mem_data_rd_data = ld_word_q;
      3'b100:  bus.data_mem_data_rd_data = {24'h0, ld_byte};
      3'b101:  bus.data_mem_data_rd_data = {16'h0, ld_half};
      default: bus.data_mem_data_rd_data = '0;
    endcase
  end

`ifndef RV_IMEM_WAIT_STATES_EN
  logic [AW-1:0]   fetch_idx;
  logic [size-1:0] instr_q;
  logic            valid_q;
  assign fetch_idx = bus.ins_address[AW+1:2];

  // Non-blocking read returns the pre-store word on a same-cycle fetch/store collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= Nop;
      valid_q <= 1'b0;
    end else begin
      instr_q <= mem[fetch_idx];
      valid_q <= 1'b1;
    end
  end

  assign bus.instruction_i     = instr_q;
  assign bus.instruction_valid = valid_q;
`else
  typedef enum logic [1:0] {StIdle, StWait, StResp} fetch_state_e;
  localparam int unsigned CW = (IMEM_WAIT > 1) ? $clog2(IMEM_WAIT + 1) : 1;

  fetch_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] lat_q, lat_d;
  logic [size-1:0] instr_q;
  logic            fetch_load;
  logic            addr_match;

  assign addr_match = (bus.ins_address == lat_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      instr_q <= Nop;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      if (fetch_load) instr_q <= mem[lat_q[AW+1:2]];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    fetch_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StWait;
        lat_d   = bus.ins_address;
        cnt_d   = CW'(IMEM_WAIT);
      end
      StWait: begin
        if (!addr_match) begin
          lat_d = bus.ins_address;
          cnt_d = CW'(IMEM_WAIT);
        end else if (cnt_q == '0) begin
          fetch_load = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (!addr_match) begin
          lat_d   = bus.ins_address;
          cnt_d   = CW'(IMEM_WAIT);
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid drops in the same cycle the core moves to a different address.
  always_comb begin
    bus.instruction_valid = (state_q == StResp) && addr_match;
  end

  assign bus.instruction_i = instr_q;
`endif
endmodule
